// File: rtl/swd_seq_gen.sv
// Bit-serial generator for SWD special line sequences (line reset, idle zeros,
// JTAG-to-SWD select, full switch) feeding the frontend's mosi/rnw/oe_n inputs.
module swd_seq_gen #(
  parameter int          LEN_W       = 8,
  parameter int          RESET_BITS  = 64,
  parameter int          MIN_RESET   = 50,
  parameter int          SWITCH_IDLE = 8,
  parameter logic [15:0] MAGIC       = 16'hE79E
) (
  input  logic             sck,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             mosi,
  output logic             rnw,
  output logic             output_enable_n
);

  if (RESET_BITS > (1 << LEN_W) || MIN_RESET > (1 << LEN_W) ||
      SWITCH_IDLE > (1 << LEN_W) || LEN_W < 4) begin : g_bad_params
    $error("swd_seq_gen: phase lengths do not fit the LEN_W counter");
  end

  typedef enum logic [2:0] {S_IDLE, S_ONES, S_MAGIC, S_ONES2, S_ZEROS} state_t;

  localparam logic [1:0] OP_LINE_RESET = 2'd0;
  localparam logic [1:0] OP_IDLE_ZERO  = 2'd1;
  localparam logic [1:0] OP_JTAG_SWD   = 2'd2;

  localparam logic [LEN_W-1:0] RESET_LOAD = LEN_W'(RESET_BITS - 1);
  localparam logic [LEN_W-1:0] MIN_LOAD   = LEN_W'(MIN_RESET - 1);
  localparam logic [LEN_W-1:0] IDLE_LOAD  = LEN_W'(SWITCH_IDLE - 1);
  localparam logic [LEN_W-1:0] MAGIC_LOAD = LEN_W'(15);

  state_t           state, state_next;
  logic [LEN_W-1:0] cnt, cnt_next;
  logic             switch_mode, switch_next;
  logic             done_reg, done_next;
  logic             last_bit;

  assign last_bit = (cnt == '0);

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      switch_mode <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      switch_mode <= switch_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt - LEN_W'(1);
    switch_next = switch_mode;
    done_next   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_next = cnt;
        if (cmd_valid) begin
          switch_next = 1'b0;
          unique case (cmd_op)
            OP_LINE_RESET: begin
              state_next = S_ONES;
              if (cmd_len == '0)
                cnt_next = RESET_LOAD;
              else if ({1'b0, cmd_len} < (LEN_W + 1)'(MIN_RESET))
                cnt_next = MIN_LOAD;
              else
                cnt_next = cmd_len - LEN_W'(1);
            end
            OP_IDLE_ZERO: begin
              // Zero-length idle emits nothing but still acknowledges with done.
              if (cmd_len == '0) begin
                done_next = 1'b1;
              end else begin
                state_next = S_ZEROS;
                cnt_next   = cmd_len - LEN_W'(1);
              end
            end
            OP_JTAG_SWD: begin
              state_next = S_MAGIC;
              cnt_next   = MAGIC_LOAD;
            end
            default: begin
              state_next  = S_ONES;
              cnt_next    = RESET_LOAD;
              switch_next = 1'b1;
            end
          endcase
        end
      end
      S_ONES: begin
        if (last_bit) begin
          if (switch_mode) begin
            state_next = S_MAGIC;
            cnt_next   = MAGIC_LOAD;
          end else begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      S_MAGIC: begin
        if (last_bit) begin
          if (switch_mode) begin
            state_next = S_ONES2;
            cnt_next   = RESET_LOAD;
          end else begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      S_ONES2: begin
        if (last_bit) begin
          state_next = S_ZEROS;
          cnt_next   = IDLE_LOAD;
        end
      end
      S_ZEROS: begin
        if (last_bit) begin
          state_next  = S_IDLE;
          switch_next = 1'b0;
          done_next   = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Counter runs 15..0 in S_MAGIC, so ~cnt[3:0] walks the word LSB first.
  always_comb begin
    mosi = 1'b0;
    unique case (state)
      S_ONES, S_ONES2: mosi = 1'b1;
      S_MAGIC:         mosi = MAGIC[~cnt[3:0]];
      default:         mosi = 1'b0;
    endcase
  end

  assign busy            = (state != S_IDLE);
  assign output_enable_n = ~busy;
  assign cmd_ready       = (state == S_IDLE);
  assign rnw             = 1'b0;
  assign done            = done_reg;

endmodule

// File: tb/tb_swd_seq_gen.sv
// Directed bench for swd_seq_gen: captures each emitted sequence bit by bit
// and compares lengths, patterns and handshake flags against hand-computed values.
module tb_swd_seq_gen;

  logic       sck = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       busy, done, mosi, rnw, output_enable_n;

  int errors = 0;
  int checks = 0;

  swd_seq_gen dut (
    .sck(sck), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .busy(busy), .done(done),
    .mosi(mosi), .rnw(rnw), .output_enable_n(output_enable_n)
  );

  always #5 sck = ~sck;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_ones(input logic [255:0] v, input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += (v[i] === 1'b1) ? 1 : 0;
    return s;
  endfunction

  // Called at a negedge: offers the command, lets it be accepted, returns at
  // the following negedge (first emission cycle) with new garbage on cmd_op/len.
  task automatic issue(input logic [1:0] op, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    check("ready_before_accept", cmd_ready, 1);
    @(posedge sck);
    @(negedge sck);
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    cmd_len   = 8'd200;
  endtask

  // Records mosi while busy. limit<0 means run to completion and check the
  // done cycle; pulse_at>=0 offers a stray command during that emitted bit.
  task automatic collect(input int limit, input int pulse_at,
                         output int n, output logic [255:0] bits);
    int bad = 0;
    n    = 0;
    bits = '0;
    for (int c = 0; c < 400; c++) begin
      if (busy !== 1'b1) break;
      if (n == limit) break;
      bits[n] = mosi;
      if (output_enable_n !== 1'b0 || done !== 1'b0 || rnw !== 1'b0 || cmd_ready !== 1'b0)
        bad++;
      cmd_valid = (n == pulse_at);
      cmd_op    = 2'd2;
      n++;
      @(negedge sck);
    end
    cmd_valid = 1'b0;
    check("emit_flags", bad, 0);
    if (limit < 0) begin
      check("busy_release", busy, 0);
      check("done_pulse", done, 1);
      check("oe_release", output_enable_n, 1);
      check("ready_release", cmd_ready, 1);
      check("mosi_gap", mosi, 0);
    end
  endtask

  initial begin
    int           n;
    logic [255:0] bits;
    logic [15:0]  magic_exp = 16'hE79E;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rnw", rnw, 0);
    check("rst_oe_n", output_enable_n, 1);
    check("rst_ready", cmd_ready, 1);
    @(negedge sck);
    rst_n = 1'b1;
    @(negedge sck);

    // T1 default line reset
    issue(2'd0, 8'd0);
    collect(-1, -1, n, bits);
    $display("cmd LINE_RESET len=0 bits=%0d", n);
    check("t1_len", n, 64);
    check("t1_ones", count_ones(bits, 0, 255), 64);
    @(negedge sck);
    check("t1_done_single", done, 0);

    // T2 clamped and unclamped line reset
    issue(2'd0, 8'd10);
    collect(-1, -1, n, bits);
    $display("cmd LINE_RESET len=10 bits=%0d", n);
    check("t2_clamp_len", n, 50);
    check("t2_clamp_ones", count_ones(bits, 0, 255), 50);
    @(negedge sck);
    issue(2'd0, 8'd70);
    collect(-1, -1, n, bits);
    $display("cmd LINE_RESET len=70 bits=%0d", n);
    check("t2_len70", n, 70);
    check("t2_ones70", count_ones(bits, 0, 255), 70);

    // T3 issued back-to-back in the done cycle: one gap cycle only
    issue(2'd2, 8'd0);
    collect(-1, -1, n, bits);
    $display("cmd JTAG_TO_SWD bits=%0d pattern=%04h", n, bits[15:0]);
    check("t3_len", n, 16);
    check("t3_pattern", bits[15:0], magic_exp);
    @(negedge sck);

    // T4 full switch
    issue(2'd3, 8'd0);
    collect(-1, -1, n, bits);
    $display("cmd SWITCH bits=%0d", n);
    check("t4_len", n, 152);
    check("t4_ones1", count_ones(bits, 0, 63), 64);
    check("t4_magic", bits[79:64], magic_exp);
    check("t4_ones2", count_ones(bits, 80, 143), 64);
    check("t4_zeros", count_ones(bits, 144, 151), 0);
    @(negedge sck);
    check("t4_done_single", done, 0);

    // T5 idle zeros
    issue(2'd1, 8'd0);
    $display("cmd IDLE_ZERO len=0");
    check("t5_zero_busy", busy, 0);
    check("t5_zero_done", done, 1);
    check("t5_zero_oe", output_enable_n, 1);
    @(negedge sck);
    check("t5_zero_done_end", done, 0);
    issue(2'd1, 8'd50);
    collect(-1, -1, n, bits);
    $display("cmd IDLE_ZERO len=50 bits=%0d", n);
    check("t5_len50", n, 50);
    check("t5_ones50", count_ones(bits, 0, 255), 0);
    @(negedge sck);

    // T6 asynchronous reset mid-sequence
    issue(2'd0, 8'd0);
    collect(30, -1, n, bits);
    $display("cmd LINE_RESET len=0 interrupted at bit %0d", n);
    check("t6_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mosi", mosi, 0);
    check("t6_rst_oe", output_enable_n, 1);
    check("t6_rst_done", done, 0);
    @(negedge sck);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sck);
      check("t6_after_done", done, 0);
      check("t6_after_busy", busy, 0);
    end

    // T6 stray cmd_valid while busy must not queue anything
    issue(2'd0, 8'd60);
    collect(-1, 5, n, bits);
    $display("cmd LINE_RESET len=60 with stray valid bits=%0d", n);
    check("t6_len60", n, 60);
    for (int i = 0; i < 5; i++) begin
      @(negedge sck);
      check("t6_no_extra", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
